// File: rtl/arashi_rd_collector_if.sv
// rtl/arashi_rd_collector_if.sv - merged read-data output stream (valid/ready, data, thread id)
interface arashi_rd_collector_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_NUM_WIDTH = 2
);
  logic                        m_valid;
  logic                        m_ready;
  logic [DATA_WIDTH-1:0]       m_data;
  logic [THREAD_NUM_WIDTH-1:0] m_tid;

  modport master (output m_valid, output m_data, output m_tid, input m_ready);
  modport slave  (input m_valid, input m_data, input m_tid, output m_ready);
endinterface

// File: rtl/arashi_rd_collector.sv
// rtl/arashi_rd_collector.sv - per-thread read FIFOs merged round-robin into one tagged stream
// Optional same-cycle bypass into the output register when ARASHI_RDC_BYPASS_EN is defined.
module arashi_rd_collector #(
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int DEPTH_WIDTH      = 2
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic [(1<<THREAD_NUM_WIDTH)-1:0]              r_ready,
  input  logic [DATA_WIDTH*(1<<THREAD_NUM_WIDTH)-1:0]   data_in,
  arashi_rd_collector_if.master                         m_if,
  output logic [(1<<THREAD_NUM_WIDTH)-1:0]              full,
  output logic [(1<<THREAD_NUM_WIDTH)-1:0]              overflow
);
  localparam int TN    = 1 << THREAD_NUM_WIDTH;
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] DEPTH_CNT = (DEPTH_WIDTH+1)'(DEPTH);

  typedef logic [THREAD_NUM_WIDTH-1:0] tid_t;

  if (THREAD_NUM_WIDTH < 2 || THREAD_NUM_WIDTH > 4) begin : g_bad_tnw
    $error("THREAD_NUM_WIDTH out of range 2..4");
  end
  if (DEPTH_WIDTH < 1 || DEPTH_WIDTH > 4) begin : g_bad_dw
    $error("DEPTH_WIDTH out of range 1..4");
  end

  logic [DATA_WIDTH-1:0]  mem    [TN][DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr [TN];
  logic [DEPTH_WIDTH-1:0] rd_ptr [TN];
  logic [DEPTH_WIDTH:0]   count  [TN];
  logic [DEPTH_WIDTH:0]   count_next [TN];
  tid_t                   rr_ptr;

  logic [TN-1:0] nonempty, req, pop, push, drop, bypass_sel;
  logic          any_nonempty, free, grant, bypass;
  tid_t          winner;

  always_comb begin
    free = !m_if.m_valid || m_if.m_ready;
    for (int i = 0; i < TN; i++) nonempty[i] = (count[i] != '0);
    any_nonempty = |nonempty;
`ifdef ARASHI_RDC_BYPASS_EN
    // With every FIFO empty the arbiter picks among the incoming strobes instead.
    req    = any_nonempty ? nonempty : r_ready;
    bypass = free && !any_nonempty && (|r_ready);
`else
    req    = nonempty;
    bypass = 1'b0;
`endif
  end

  // Walk from farthest to nearest so the first requester after rr_ptr wins.
  always_comb begin
    winner = '0;
    for (int k = TN; k >= 1; k--) begin
      if (req[rr_ptr + tid_t'(k)]) winner = rr_ptr + tid_t'(k);
    end
  end

  always_comb begin
    grant = free && any_nonempty;
    for (int i = 0; i < TN; i++) begin
      pop[i]        = grant && (winner == tid_t'(i));
      bypass_sel[i] = bypass && (winner == tid_t'(i));
      push[i]       = r_ready[i] && !bypass_sel[i] && ((count[i] < DEPTH_CNT) || pop[i]);
      drop[i]       = r_ready[i] && !bypass_sel[i] && !((count[i] < DEPTH_CNT) || pop[i]);
      count_next[i] = count[i] + (DEPTH_WIDTH+1)'(push[i]) - (DEPTH_WIDTH+1)'(pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < TN; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < TN; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      full          <= '0;
      overflow      <= '0;
      rr_ptr        <= tid_t'(TN - 1);
      m_if.m_valid  <= 1'b0;
      m_if.m_data   <= '0;
      m_if.m_tid    <= '0;
    end else begin
      for (int i = 0; i < TN; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (drop[i]) overflow[i] <= 1'b1;
        count[i] <= count_next[i];
        full[i]  <= (count_next[i] == DEPTH_CNT);
      end
      if (free) begin
        if (grant) begin
          m_if.m_valid <= 1'b1;
          m_if.m_data  <= mem[winner][rd_ptr[winner]];
          m_if.m_tid   <= winner;
          rr_ptr       <= winner;
        end else if (bypass) begin
          m_if.m_valid <= 1'b1;
          m_if.m_data  <= data_in[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
          m_if.m_tid   <= winner;
          rr_ptr       <= winner;
        end else begin
          m_if.m_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_arashi_rd_collector.sv
// tb/tb_arashi_rd_collector.sv - directed bench with queue-based reference model for arashi_rd_collector
module tb_arashi_rd_collector;
  localparam int DW    = 32;
  localparam int TW    = 2;
  localparam int TN    = 4;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic [TN-1:0]     r_ready = '0;
  logic [DW*TN-1:0]  data_in = '0;
  logic [TN-1:0]     full, overflow;

  always #5 clk = ~clk;

  arashi_rd_collector_if #(.DATA_WIDTH(DW), .THREAD_NUM_WIDTH(TW)) bus ();

  arashi_rd_collector #(.DATA_WIDTH(DW), .THREAD_NUM_WIDTH(TW), .DEPTH_WIDTH(2)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .r_ready  (r_ready),
    .data_in  (data_in),
    .m_if     (bus),
    .full     (full),
    .overflow (overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-thread queues, one output slot, integer rr pointer.
  logic [DW-1:0] mq [TN][$];
  bit            mv;
  logic [DW-1:0] md;
  int            mtid;
  int            rr;
  bit [TN-1:0]   mfull, movf;
  bit            started = 0;
  int            sz [TN];
  int            win, bw, j;
  bit            fr, anyq;
  logic [DW-1:0] pw;

  always @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < TN; i++) mq[i].delete();
      mv = 0; md = '0; mtid = 0; rr = TN - 1; movf = '0; mfull = '0; started = 1;
    end else if (started) begin
      fr = !mv || bus.m_ready;
      anyq = 0;
      for (int i = 0; i < TN; i++) begin
        sz[i] = mq[i].size();
        if (sz[i] > 0) anyq = 1;
      end
      win = -1; bw = -1; pw = '0;
      if (fr && anyq) begin
        for (int k = 1; k <= TN; k++) begin
          j = (rr + k) % TN;
          if (win < 0 && sz[j] > 0) win = j;
        end
      end
`ifdef ARASHI_RDC_BYPASS_EN
      if (fr && !anyq) begin
        for (int k = 1; k <= TN; k++) begin
          j = (rr + k) % TN;
          if (bw < 0 && r_ready[j]) bw = j;
        end
      end
`endif
      if (win >= 0) pw = mq[win].pop_front();
      for (int i = 0; i < TN; i++) begin
        if (r_ready[i] && i != bw) begin
          if (sz[i] < DEPTH || i == win) mq[i].push_back(data_in[i*DW +: DW]);
          else movf[i] = 1;
        end
      end
      if (fr) begin
        if (win >= 0) begin
          mv = 1; md = pw; mtid = win; rr = win;
        end else if (bw >= 0) begin
          mv = 1; md = data_in[bw*DW +: DW]; mtid = bw; rr = bw;
        end else begin
          mv = 0;
        end
      end
      for (int i = 0; i < TN; i++) mfull[i] = (mq[i].size() == DEPTH);
    end
  end

  typedef struct { int tid; logic [DW-1:0] data; } beat_t;
  beat_t beats [$];

  always @(negedge clk) begin
    if (started) begin
      chk("m_valid", 64'(bus.m_valid), 64'(mv));
      if (mv) begin
        chk("m_data", 64'(bus.m_data), 64'(md));
        chk("m_tid", 64'(bus.m_tid), 64'(mtid));
      end
      chk("full", 64'(full), 64'(mfull));
      chk("overflow", 64'(overflow), 64'(movf));
      if (bus.m_valid && bus.m_ready && !rstn) beats.push_back('{int'(bus.m_tid), bus.m_data});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rstn = 1'b1;
    r_ready = '0;
    tick(1);
    rstn = 1'b0;
    beats.delete();
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] v);
    data_in[i*DW +: DW] = v;
  endtask

  initial begin
    bus.m_ready = 1'b0;

    // 1: reset with strobes active
    rstn = 1'b1; r_ready = 4'b1111;
    tick(2);
    rstn = 1'b0; r_ready = '0;
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);

    // 2: single word latency
    do_reset;
    bus.m_ready = 1'b1;
    r_ready = 4'b0100; set_word(2, 32'hDEADBEEF);
    tick(1);
    r_ready = '0;
`ifndef ARASHI_RDC_BYPASS_EN
    chk("single_n1_idle", 64'(bus.m_valid), 64'd0);
    tick(1);
`endif
    chk("single_valid", 64'(bus.m_valid), 64'd1);
    chk("single_data", 64'(bus.m_data), 64'hDEADBEEF);
    chk("single_tid", 64'(bus.m_tid), 64'd2);
    tick(1);
    chk("single_done", 64'(bus.m_valid), 64'd0);
    tick(3);
    chk("single_beats", 64'(beats.size()), 64'd1);

    // 3: round-robin fairness
    do_reset;
    bus.m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      r_ready = 4'b1111;
      for (int i = 0; i < TN; i++) set_word(i, 32'(k*16 + i));
      tick(1);
    end
    r_ready = '0;
    tick(16);
    chk("rr_beats", 64'(beats.size()), 64'd12);
    for (int b = 0; b < beats.size() && b < 12; b++) begin
      chk("rr_tid", 64'(beats[b].tid), 64'(b % 4));
      chk("rr_data", 64'(beats[b].data), 64'((b / 4) * 16 + (b % 4)));
    end

    // 4: backpressure and overflow
    do_reset;
    bus.m_ready = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      r_ready = 4'b0001; set_word(0, 32'h100 + 32'(n));
      tick(1);
      if (n == 4) chk("bp_full4", 64'(full[0]), 64'd0);
      if (n == 5) begin
        chk("bp_full5", 64'(full[0]), 64'd1);
        chk("bp_ovf5", 64'(overflow[0]), 64'd0);
      end
    end
    r_ready = '0;
    chk("bp_ovf6", 64'(overflow[0]), 64'd1);
    tick(2);
    chk("bp_hold_valid", 64'(bus.m_valid), 64'd1);
    chk("bp_hold_data", 64'(bus.m_data), 64'h101);
    bus.m_ready = 1'b1;
    tick(10);
    chk("bp_beats", 64'(beats.size()), 64'd5);
    for (int b = 0; b < beats.size() && b < 5; b++)
      chk("bp_data", 64'(beats[b].data), 64'(32'h101 + 32'(b)));

    // 5: push into a full FIFO while it is popped
    do_reset;
    bus.m_ready = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      r_ready = 4'b0001; set_word(0, 32'h100 + 32'(n));
      tick(1);
    end
    bus.m_ready = 1'b1;
    r_ready = 4'b0001; set_word(0, 32'h106);
    tick(1);
    r_ready = '0;
    chk("pp_ovf", 64'(overflow[0]), 64'd0);
    chk("pp_full", 64'(full[0]), 64'd1);
    tick(10);
    chk("pp_beats", 64'(beats.size()), 64'd6);
    for (int b = 0; b < beats.size() && b < 6; b++)
      chk("pp_data", 64'(beats[b].data), 64'(32'h101 + 32'(b)));

    // 6: reset mid-stream
    do_reset;
    bus.m_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      r_ready = 4'b0111;
      for (int i = 0; i < TN; i++) set_word(i, 32'h200 + 32'(k*16 + i));
      tick(1);
    end
    r_ready = '0;
    tick(1);
    chk("mid_valid_held", 64'(bus.m_valid), 64'd1);
    rstn = 1'b1;
    tick(1);
    rstn = 1'b0;
    chk("mid_valid_clr", 64'(bus.m_valid), 64'd0);
    chk("mid_full_clr", 64'(full), 64'd0);
    beats.delete();
    bus.m_ready = 1'b1;
    r_ready = 4'b0010; set_word(1, 32'hCAFE);
    tick(1);
    r_ready = '0;
    tick(6);
    chk("mid_beats", 64'(beats.size()), 64'd1);
    if (beats.size() > 0) begin
      chk("mid_tid", 64'(beats[0].tid), 64'd1);
      chk("mid_data", 64'(beats[0].data), 64'hCAFE);
    end

    // 7: mixed traffic with patterned backpressure, checked by the model each cycle
    do_reset;
    for (int c = 0; c < 60; c++) begin
      bus.m_ready = (c % 3) != 0;
      r_ready = (c % 7 == 6) ? 4'b0000 : 4'((c * 5 + 3) % 16);
      for (int i = 0; i < TN; i++) set_word(i, 32'(c * 256 + i));
      tick(1);
    end
    r_ready = '0;
    bus.m_ready = 1'b1;
    tick(24);
    chk("mix_drained", 64'(bus.m_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
